// File: rtl/color_transform.sv
`default_nettype none
// ============================================================================
//  Module   : color_transform
//  Purpose  : Streaming RGB-to-greyscale converter. Each 24-bit RGB pixel is
//             reduced to BT.601 luma Y = (77R + 150G + 29B + 128) >> 8 and
//             Y is replicated onto all three output bytes.
//             Three register stages:
//               S1 - captured R, G, B
//               S2 - the three weighted products
//               S3 - rounded Y (drives the outputs)
//             The whole pipeline advances together. It stalls only while
//             the output holds a valid result that downstream refuses.
//  Ports    : i_clk        in   1   clock, rising edge
//             i_rst        in   1   asynchronous reset, active low
//             i_rgb_busy   out  1   1 = pixel cannot be accepted this cycle
//             i_rgb_vld    in   1   1 = i_rgb_data holds a valid pixel
//             i_rgb_data   in   24  R=[23:16], G=[15:8], B=[7:0]
//             o_grey_busy  in   1   1 = downstream cannot accept this cycle
//             o_grey_vld   out  1   1 = o_grey_data holds a valid result
//             o_grey_data  out  24  {Y,Y,Y}
//  Revision : 1.0  initial release
// ============================================================================
module color_transform (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        i_rgb_busy,
    input  logic        i_rgb_vld,
    input  logic [23:0] i_rgb_data,
    input  logic        o_grey_busy,
    output logic        o_grey_vld,
    output logic [23:0] o_grey_data
);

    localparam logic [14:0] C_WR   = 15'd77;
    localparam logic [15:0] C_WG   = 16'd150;
    localparam logic [12:0] C_WB   = 13'd29;
    localparam logic [15:0] C_RND  = 16'd128;

    // Stage registers
    logic        r_s1_vld;
    logic [7:0]  r_s1_r;
    logic [7:0]  r_s1_g;
    logic [7:0]  r_s1_b;

    logic        r_s2_vld;
    logic [14:0] r_s2_pr;
    logic [15:0] r_s2_pg;
    logic [12:0] r_s2_pb;

    logic        r_s3_vld;
    logic [7:0]  r_s3_y;

    // Combinational
    logic        w_en;
    logic        w_accept;
    logic [14:0] w_pr;
    logic [15:0] w_pg;
    logic [12:0] w_pb;
    logic [15:0] w_sum;
    logic [7:0]  w_y;

    // Global advance: only a refused valid result can stall the pipeline.
    // A bubble in S3 never blocks, so no extra bubble is ever inserted.
    assign w_en       = ~(r_s3_vld & o_grey_busy);
    assign i_rgb_busy = ~w_en;
    assign w_accept   = i_rgb_vld & ~i_rgb_busy;

    // Products sized exactly: 77*255 < 2^15, 150*255 < 2^16, 29*255 < 2^13
    assign w_pr = 15'(r_s1_r) * C_WR;
    assign w_pg = 16'(r_s1_g) * C_WG;
    assign w_pb = 13'(r_s1_b) * C_WB;

    // Worst case 19635 + 38250 + 7395 + 128 = 65408, so 16 bits never wrap
    assign w_sum = 16'(r_s2_pr) + r_s2_pg + 16'(r_s2_pb) + C_RND;
    assign w_y   = 8'(w_sum >> 8);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_s1_vld <= 1'b0;
            r_s1_r   <= 8'd0;
            r_s1_g   <= 8'd0;
            r_s1_b   <= 8'd0;
            r_s2_vld <= 1'b0;
            r_s2_pr  <= 15'd0;
            r_s2_pg  <= 16'd0;
            r_s2_pb  <= 13'd0;
            r_s3_vld <= 1'b0;
            r_s3_y   <= 8'd0;
        end else if (w_en) begin
            r_s1_vld <= w_accept;
            r_s2_vld <= r_s1_vld;
            r_s3_vld <= r_s2_vld;

            // Data registers only load behind a valid token, so the output
            // keeps its last result while bubbles pass through.
            if (w_accept) begin
                r_s1_r <= i_rgb_data[23:16];
                r_s1_g <= i_rgb_data[15:8];
                r_s1_b <= i_rgb_data[7:0];
            end
            if (r_s1_vld) begin
                r_s2_pr <= w_pr;
                r_s2_pg <= w_pg;
                r_s2_pb <= w_pb;
            end
            if (r_s2_vld) begin
                r_s3_y <= w_y;
            end
        end
    end

    assign o_grey_vld  = r_s3_vld;
    assign o_grey_data = {r_s3_y, r_s3_y, r_s3_y};

endmodule
`default_nettype wire

// File: tb/tb_color_transform.sv
`default_nettype none
// ============================================================================
//  Module   : tb_color_transform
//  Purpose  : Self-checking bench for color_transform. Expected luma values
//             are pushed to a scoreboard queue on every accepted input and
//             popped on every emitted output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_color_transform;

    logic        i_clk;
    logic        i_rst;
    logic        i_rgb_busy;
    logic        i_rgb_vld;
    logic [23:0] i_rgb_data;
    logic        o_grey_busy;
    logic        o_grey_vld;
    logic [23:0] o_grey_data;

    int          n_tests;
    int          n_fail;
    int          n_acc;
    int          n_out;
    logic [23:0] sb[$];

    color_transform u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rgb_busy  (i_rgb_busy),
        .i_rgb_vld   (i_rgb_vld),
        .i_rgb_data  (i_rgb_data),
        .o_grey_busy (o_grey_busy),
        .o_grey_vld  (o_grey_vld),
        .o_grey_data (o_grey_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [23:0] grey_of(input logic [23:0] rgb);
        int y;
        y = (77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]) + 128) / 256;
        return {y[7:0], y[7:0], y[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: transfers are decided at the next rising edge, so the
    // handshake is inspected at the falling edge beforehand.
    always @(negedge i_clk) begin
        if (i_rst) begin
            if (i_rgb_vld && !i_rgb_busy) begin
                sb.push_back(grey_of(i_rgb_data));
                n_acc++;
            end
            if (o_grey_vld && !o_grey_busy) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    check("sb_data", 32'(o_grey_data), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        i_rgb_vld   = 1'b0;
        o_grey_busy = 1'b0;
        while (sb.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Single directed pixel: captured at edge k, visible after edge k+2
    task automatic send_single(input logic [23:0] rgb, input logic [23:0] exp);
        i_rgb_vld  = 1'b1;
        i_rgb_data = rgb;
        tick();
        i_rgb_vld  = 1'b0;
        i_rgb_data = 24'h0;
        check("single_lat1", 32'(o_grey_vld), 32'd0);
        tick();
        check("single_lat2", 32'(o_grey_vld), 32'd0);
        tick();
        check("single_vld", 32'(o_grey_vld), 32'd1);
        check("single_data", 32'(o_grey_data), 32'(exp));
        tick();
    endtask

    initial begin
        logic [23:0] snap_data;
        logic        snap_vld;
        int          cyc;
        int          base;

        n_tests     = 0;
        n_fail      = 0;
        n_acc       = 0;
        n_out       = 0;
        i_rst       = 1'b0;
        i_rgb_vld   = 1'b0;
        i_rgb_data  = 24'h0;
        o_grey_busy = 1'b0;

        tick();
        tick();
        check("rst_vld", 32'(o_grey_vld), 32'd0);
        check("rst_data", 32'(o_grey_data), 32'd0);
        check("rst_busy", 32'(i_rgb_busy), 32'd0);
        i_rst = 1'b1;
        tick();

        // Directed single pixels
        send_single(24'hFFFFFF, 24'hFFFFFF);
        send_single(24'h000000, 24'h000000);
        send_single(24'hFF0000, 24'h4D4D4D);
        send_single(24'h00FF00, 24'h959595);
        send_single(24'h0000FF, 24'h1D1D1D);
        drain("single_drain");

        // Back-to-back stream of 16, no backpressure
        base = n_out;
        for (int i = 0; i < 16; i++) begin
            i_rgb_vld  = 1'b1;
            i_rgb_data = 24'($urandom);
            check("b2b_in_busy", 32'(i_rgb_busy), 32'd0);
            tick();
            if (i >= 2) check("b2b_out_vld", 32'(o_grey_vld), 32'd1);
        end
        i_rgb_vld = 1'b0;
        tick();
        check("b2b_tail_vld", 32'(o_grey_vld), 32'd1);
        drain("b2b_drain");
        check("b2b_count", 32'(n_out - base), 32'd16);

        // Backpressure: fill pipeline, then refuse output for 5 cycles
        for (int i = 0; i < 4; i++) begin
            i_rgb_vld  = 1'b1;
            i_rgb_data = 24'($urandom);
            tick();
        end
        o_grey_busy = 1'b1;
        #1;
        snap_data = o_grey_data;
        snap_vld  = o_grey_vld;
        check("bp_snap_vld", 32'(snap_vld), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_busy", 32'(i_rgb_busy), 32'd1);
            i_rgb_data = 24'($urandom);
            tick();
            check("bp_hold_vld", 32'(o_grey_vld), 32'(snap_vld));
            check("bp_hold_data", 32'(o_grey_data), 32'(snap_data));
        end
        o_grey_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_rgb_data = 24'($urandom);
            tick();
        end
        drain("bp_drain");

        // Random valid/busy toggling over 1000 accepted pixels
        base = n_acc;
        cyc  = 0;
        while ((n_acc - base) < 1000 && cyc < 20000) begin
            i_rgb_vld   = 1'($urandom_range(0, 1));
            i_rgb_data  = 24'($urandom);
            o_grey_busy = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check("rand_accepted", 32'(n_acc - base >= 1000), 32'd1);
        drain("rand_drain");

        // Asynchronous reset with three pixels in flight
        for (int i = 0; i < 3; i++) begin
            i_rgb_vld  = 1'b1;
            i_rgb_data = 24'($urandom);
            tick();
        end
        #2;
        i_rst = 1'b0;
        #1;
        check("arst_vld", 32'(o_grey_vld), 32'd0);
        check("arst_data", 32'(o_grey_data), 32'd0);
        sb.delete();
        // Valid held high throughout reset: nothing may be captured
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_hold_vld", 32'(o_grey_vld), 32'd0);
        end
        i_rgb_vld = 1'b0;
        i_rst     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_empty", 32'(o_grey_vld), 32'd0);
        end
        send_single(24'h123456, grey_of(24'h123456));
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
